// File: rtl/sync_debouncer_pkg.sv
// Shared constants for the debouncer slice.
package sync_debouncer_pkg;

   // Flops in each per-bit synchroniser chain (glitchy -> s1 -> s2).
   localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/sample_pulse_gen.sv
// Slow tick generator: one-cycle pulse every SAMPLE_CNT_MAX clocks.
// The first pulse after reset falls in the SAMPLE_CNT_MAX-th cycle.
module sample_pulse_gen
   import sync_debouncer_pkg::*;
#(
   parameter int unsigned SAMPLE_CNT_MAX = 62500
) (
   input  logic clk,
   input  logic rst,
   output logic sample_pulse
);

   localparam int unsigned CNT_W = $clog2(SAMPLE_CNT_MAX);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_CNT_MAX - 1);

   logic [CNT_W-1:0] count;

   // Free-running 0..SAMPLE_CNT_MAX-1 counter that wraps to 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (count == CNT_LAST) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   // Pulse while the counter sits on its last value.
   always_comb begin
      sample_pulse = (count == CNT_LAST);
   end

endmodule

// File: rtl/sync_debouncer.sv
// Per-bit 2-flop synchroniser followed by a saturating qualification counter.
// Output bit is high only once its counter has reached PULSE_CNT_MAX.
module sync_debouncer
   import sync_debouncer_pkg::*;
#(
   parameter int unsigned WIDTH          = 1,
   parameter int unsigned SAMPLE_CNT_MAX = 62500,
   parameter int unsigned PULSE_CNT_MAX  = 200
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] glitchy_signal,
   output logic [WIDTH-1:0] debounced_signal
);

   localparam int unsigned PCNT_W = $clog2(PULSE_CNT_MAX + 1);
   localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(PULSE_CNT_MAX);

   logic sample_pulse;

   sample_pulse_gen #(
      .SAMPLE_CNT_MAX(SAMPLE_CNT_MAX)
   ) u_sample_pulse_gen (
      .clk         (clk),
      .rst         (rst),
      .sample_pulse(sample_pulse)
   );

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic [SYNC_STAGES-1:0] sync_q;
      logic [PCNT_W-1:0]      pcnt;
      logic                   s2;

      assign s2 = sync_q[SYNC_STAGES-1];

      // Shift the raw input through the synchroniser chain.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sync_q <= '0;
         end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], glitchy_signal[i]};
         end
      end

      // Any low at s2 clears; high samples count up and saturate.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            pcnt <= '0;
         end else if (!s2) begin
            pcnt <= '0;
         end else if (sample_pulse && (pcnt < PCNT_MAX)) begin
            pcnt <= pcnt + 1'b1;
         end
      end

      // Registered decode only: no combinational path from the input.
      assign debounced_signal[i] = (pcnt == PCNT_MAX);
   end

endmodule
